machine_timer: RTL

Memory-mapped machine timer and software-interrupt source that sits directly upstream of the interrupt controller. It supplies `mip` bits 7 (MTIP) and 3 (MSIP) via the `interrupts` vector. It holds the 64-bit `mtime` counter, the 64-bit `mtimecmp` compare register and the `msip` bit, all reachable over the core's single-word data bus with a req/ack handshake.

---
 rtl/machine_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/machine_timer.sv
// Machine timer and software-interrupt source with a req/ack register bus.
// Optional prescaler compiled in with `TIMER_PRESCALE_EN`.
module machine_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic [31:0] interrupts
);

  // state   | meaning
  // ST_IDLE | waiting for bus_req; access performed on the accepting edge
  // ST_ACK  | bus_ack high for one cycle, new requests ignored
  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t      state;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] mtime_hi_shadow;
  logic        msip;
  logic        timer_irq;
  logic        tick;

  logic        accept;
  logic        aligned;
  logic [2:0]  reg_sel;
  logic [31:0] rd_mux;
  logic        wr_msip, wr_cmp_lo, wr_cmp_hi, wr_time_lo, wr_time_hi, rd_time_lo;

  if (PRESCALE == 0 || PRESCALE > 65535) begin : g_bad_prescale
    $error("machine_timer: PRESCALE must be 1..65535");
  end

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  logic [15:0] pre_cnt;

  assign tick = (pre_cnt == PRE_LAST);

  // free-running: mtime writes deliberately leave the phase alone
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  assign accept  = (state == ST_IDLE) && bus_req;
  assign aligned = (bus_addr[1:0] == 2'b00);
  assign reg_sel = bus_addr[4:2];

  assign wr_msip    = accept && bus_we  && aligned && (reg_sel == 3'd0);
  assign wr_cmp_lo  = accept && bus_we  && aligned && (reg_sel == 3'd1);
  assign wr_cmp_hi  = accept && bus_we  && aligned && (reg_sel == 3'd2);
  assign wr_time_lo = accept && bus_we  && aligned && (reg_sel == 3'd3);
  assign wr_time_hi = accept && bus_we  && aligned && (reg_sel == 3'd4);
  assign rd_time_lo = accept && !bus_we && aligned && (reg_sel == 3'd3);

  always_comb begin
    rd_mux = '0;
    if (aligned) begin
      case (reg_sel)
        3'd0:    rd_mux = {31'b0, msip};
        3'd1:    rd_mux = mtimecmp[31:0];
        3'd2:    rd_mux = mtimecmp[63:32];
        3'd3:    rd_mux = mtime[31:0];
        3'd4:    rd_mux = mtime_hi_shadow;
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      bus_ack         <= 1'b0;
      bus_rdata       <= '0;
      mtime           <= '0;
      mtimecmp        <= '1;
      mtime_hi_shadow <= '0;
      msip            <= 1'b0;
      timer_irq       <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);

      case (state)
        ST_IDLE: begin
          if (bus_req) begin
            state     <= ST_ACK;
            bus_ack   <= 1'b1;
            bus_rdata <= bus_we ? '0 : rd_mux;
          end
        end
        ST_ACK: begin
          state   <= ST_IDLE;
          bus_ack <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          bus_ack <= 1'b0;
        end
      endcase

      if (wr_msip)   msip            <= bus_wdata[0];
      if (wr_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= bus_wdata;

      // a software write to either half swallows that cycle's tick
      if (wr_time_lo) begin
        mtime[31:0] <= bus_wdata;
      end else if (wr_time_hi) begin
        mtime[63:32] <= bus_wdata;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr_time_hi) begin
        mtime_hi_shadow <= bus_wdata;
      end else if (rd_time_lo) begin
        mtime_hi_shadow <= mtime[63:32];
      end
    end
  end

  assign interrupts = {24'b0, timer_irq, 3'b0, msip, 3'b0};

endmodule
